// File: rtl/xy_noc_pkg.sv
// Shared NoC definitions: port indices, packet-width helpers and the XY route function.
package xy_noc_pkg;

  typedef enum logic [2:0] {
    PORT_RSC = 3'd0,
    LEFT     = 3'd1,
    UP       = 3'd2,
    RIGHT    = 3'd3,
    DOWN     = 3'd4
  } port_e;

  // Coordinate field width; a single-row/column mesh still carries a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned calc_pckt_w(input int unsigned row_n, input int unsigned col_m,
                                              input int unsigned data_w);
    return clog2_min1(col_m) + clog2_min1(row_n) + data_w;
  endfunction

  // X is resolved before Y; row 0 is the top row, so UP means a smaller row index.
  function automatic port_e route(input int unsigned dst_x, input int unsigned dst_y,
                                  input int unsigned x_cord, input int unsigned y_cord);
    if (dst_x < x_cord)      return LEFT;
    else if (dst_x > x_cord) return RIGHT;
    else if (dst_y < y_cord) return UP;
    else if (dst_y > y_cord) return DOWN;
    else                     return PORT_RSC;
  endfunction

endpackage

// File: rtl/xy_rr_router_fifo.sv
// router_in_fifo: synchronous input FIFO of 2**DEPTH_W entries, head visible while non-empty.
module router_in_fifo #(
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);
  localparam int unsigned DEPTH = 2 ** DEPTH_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH_W:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0]  rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                   (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[DEPTH_W-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{DEPTH_W{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{DEPTH_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/xy_rr_router.sv
// XY mesh router node: per-input FIFOs, per-output round-robin arbiter and output register.
// Optional XY_ROUTER_ERR_EN drops illegal heads (out-of-mesh or U-turn) and pulses err_o.
module xy_rr_router
  import xy_noc_pkg::*;
#(
  parameter  int unsigned ROW_N        = 3,
  parameter  int unsigned COL_M        = 3,
  parameter  int unsigned X_CORD       = 0,
  parameter  int unsigned Y_CORD       = 0,
  parameter  int unsigned PORT_N       = 5,
  parameter  int unsigned PCKT_DATA_W  = 8,
  parameter  int unsigned FIFO_DEPTH_W = 3,
  localparam int unsigned XA_W         = clog2_min1(COL_M),
  localparam int unsigned YA_W         = clog2_min1(ROW_N),
  localparam int unsigned PCKT_W       = calc_pckt_w(ROW_N, COL_M, PCKT_DATA_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PORT_N*PCKT_W-1:0] pckt_i,
  input  logic [PORT_N-1:0]        valid_i,
  output logic [PORT_N-1:0]        ready_o,
  output logic [PORT_N*PCKT_W-1:0] pckt_o,
  output logic [PORT_N-1:0]        valid_o,
`ifdef XY_ROUTER_ERR_EN
  output logic [PORT_N-1:0]        err_o,
`endif
  input  logic [PORT_N-1:0]        ready_i
);
  localparam int unsigned PTR_W = $clog2(PORT_N);

  logic [PORT_N-1:0][PCKT_W-1:0] pckt_in;
  logic [PCKT_W-1:0]             head [PORT_N];
  port_e                         dir  [PORT_N];
  logic [PORT_N-1:0]             full, empty, push, pop, drop, req, granted;

  logic [PORT_N-1:0][PTR_W-1:0]  ptr_q, ptr_d;
  logic [PORT_N-1:0]             valid_q, valid_d;
  logic [PORT_N-1:0][PCKT_W-1:0] pckt_q, pckt_d;

  assign pckt_in = pckt_i;
  assign ready_o = {PORT_N{rst_ni}} & ~full;
  assign push    = valid_i & ready_o;
  assign pop     = granted | drop;

  for (genvar g = 0; g < PORT_N; g++) begin : g_in
    router_in_fifo #(
      .DEPTH_W(FIFO_DEPTH_W),
      .DATA_W (PCKT_W)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push[g]),
      .pop_i  (pop[g]),
      .data_i (pckt_in[g]),
      .full_o (full[g]),
      .empty_o(empty[g]),
      .head_o (head[g])
    );
  end

  always_comb begin
    for (int unsigned p = 0; p < PORT_N; p++) begin
      dir[p] = route(32'(head[p][PCKT_W-1 -: XA_W]), 32'(head[p][PCKT_DATA_W +: YA_W]),
                     X_CORD, Y_CORD);
`ifdef XY_ROUTER_ERR_EN
      drop[p] = !empty[p] &&
                ((32'(head[p][PCKT_W-1 -: XA_W]) >= COL_M) ||
                 (32'(head[p][PCKT_DATA_W +: YA_W]) >= ROW_N) ||
                 (32'(dir[p]) == p));
`else
      drop[p] = 1'b0;
`endif
      req[p] = !empty[p] && !drop[p];
    end
  end

`ifdef XY_ROUTER_ERR_EN
  assign err_o = drop & {PORT_N{rst_ni}};
`endif

  // Each input targets one output, so a head can be granted by at most one arbiter.
  always_comb begin
    int unsigned win;
    int unsigned idx;
    logic        found;
    win     = 0;
    idx     = 0;
    found   = 1'b0;
    granted = '0;
    valid_d = valid_q;
    pckt_d  = pckt_q;
    ptr_d   = ptr_q;
    for (int unsigned o = 0; o < PORT_N; o++) begin
      if (!valid_q[o] || ready_i[o]) begin
        found = 1'b0;
        win   = 0;
        for (int unsigned i = 0; i < PORT_N; i++) begin
          idx = 32'(ptr_q[o]) + i;
          if (idx >= PORT_N) idx = idx - PORT_N;
          if (!found && req[idx] && (32'(dir[idx]) == o)) begin
            found = 1'b1;
            win   = idx;
          end
        end
        valid_d[o] = found;
        if (found) begin
          pckt_d[o]    = head[win];
          granted[win] = 1'b1;
          ptr_d[o]     = (win == PORT_N - 1) ? '0 : PTR_W'(win + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      pckt_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pckt_q  <= pckt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign pckt_o  = pckt_q;

endmodule

// File: tb/tb_xy_rr_router.sv
// Scoreboard bench for xy_rr_router at node (1,1) of a 3x3 mesh.
module tb_xy_rr_router;
  localparam int PN = 5;
  localparam int PW = 12;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [PN*PW-1:0] pckt_i;
  logic [PN-1:0]    valid_i;
  logic [PN-1:0]    ready_o;
  logic [PN*PW-1:0] pckt_o;
  logic [PN-1:0]    valid_o;
  logic [PN-1:0]    ready_i;
`ifdef XY_ROUTER_ERR_EN
  logic [PN-1:0]    err_o;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         dst;
    int         src;
    logic [11:0] pkt;
  } sb_t;
  sb_t sb[$];

  xy_rr_router #(
    .ROW_N(3), .COL_M(3), .X_CORD(1), .Y_CORD(1),
    .PORT_N(5), .PCKT_DATA_W(8), .FIFO_DEPTH_W(3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .pckt_i (pckt_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .pckt_o (pckt_o),
    .valid_o(valid_o),
`ifdef XY_ROUTER_ERR_EN
    .err_o  (err_o),
`endif
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] mk(input int x, input int y, input logic [7:0] d);
    return {2'(x), 2'(y), d};
  endfunction

  function automatic int exp_route(input int x, input int y);
    if (x < 1) return 1;
    if (x > 1) return 3;
    if (y < 1) return 2;
    if (y > 1) return 4;
    return 0;
  endfunction

  task automatic drive(input int p, input logic [11:0] pkt, input bit expect_out);
    sb_t e;
    valid_i[p]           = 1'b1;
    pckt_i[p*PW +: PW]   = pkt;
    if (ready_o[p] && expect_out) begin
      e.dst = exp_route(int'(pkt[11:10]), int'(pkt[9:8]));
      e.src = p;
      e.pkt = pkt;
      sb.push_back(e);
    end
  endtask

  // Match each output handshake to the oldest queued packet of that pair.
  always @(negedge clk) begin
    logic [11:0] got;
    int hit;
    int older;
    if (rst_ni) begin
      for (int o = 0; o < PN; o++) begin
        if (valid_o[o] && ready_i[o]) begin
          got = pckt_o[o*PW +: PW];
          hit = -1;
          for (int k = 0; k < sb.size(); k++)
            if (hit < 0 && sb[k].dst == o && sb[k].pkt == got) hit = k;
          check("sb_hit", 64'(hit >= 0), 64'(1));
          if (hit >= 0) begin
            older = 0;
            for (int k = 0; k < hit; k++)
              if (sb[k].dst == o && sb[k].src == sb[hit].src) older++;
            check("sb_order", 64'(older), 64'(0));
            sb.delete(hit);
          end
        end
      end
    end
  end

  initial begin
    int accepted;
    int first_block;
    int seq;
    int x;
    int y;
    rst_ni  = 1'b0;
    valid_i = '1;
    ready_i = '1;
    pckt_i  = '0;
    repeat (3) tick();
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_pckt", 64'(pckt_o), 64'(0));
    rst_ni  = 1'b1;
    valid_i = '0;
    tick();
    check("rel_ready", 64'(ready_o), 64'h1f);
    check("rel_valid", 64'(valid_o), 64'(0));

    // basic route to RIGHT with 2-cycle latency
    drive(0, mk(2, 1, 8'hA5), 1'b1);
    tick(); valid_i = '0;
    check("basic_c1", 64'(valid_o), 64'(0));
    tick();
    check("basic_vld", 64'(valid_o), 64'b01000);
    check("basic_pkt", 64'(pckt_o[3*PW +: PW]), 64'(mk(2, 1, 8'hA5)));
    tick();

    // X resolved before Y
    drive(0, mk(0, 2, 8'h3C), 1'b1);
    tick(); valid_i = '0; tick();
    check("xy_vld", 64'(valid_o), 64'b00010);
    check("xy_pkt", 64'(pckt_o[1*PW +: PW]), 64'(mk(0, 2, 8'h3C)));
    tick();

`ifdef XY_ROUTER_ERR_EN
    drive(1, mk(0, 1, 8'h5A), 1'b0);
    drive(0, mk(3, 1, 8'h66), 1'b0);
    tick(); valid_i = '0;
    check("err_c1", 64'(err_o), 64'b00011);
    check("err_vld_c1", 64'(valid_o), 64'(0));
    tick();
    check("err_c2", 64'(err_o), 64'(0));
    check("err_vld_c2", 64'(valid_o), 64'(0));
    tick();
`else
    drive(1, mk(0, 1, 8'h77), 1'b1);
    tick(); valid_i = '0; tick();
    check("uturn_vld", 64'(valid_o), 64'b00010);
    check("uturn_pkt", 64'(pckt_o[1*PW +: PW]), 64'(mk(0, 1, 8'h77)));
    tick();
`endif

    // round-robin on the resource port
    drive(1, mk(1, 1, 8'h11), 1'b1);
    drive(2, mk(1, 1, 8'h22), 1'b1);
    tick(); valid_i = '0; tick();
    check("arb_vld", 64'(valid_o), 64'b00001);
    check("arb_first", 64'(pckt_o[0 +: PW]), 64'(mk(1, 1, 8'h11)));
    tick();
    check("arb_second", 64'(pckt_o[0 +: PW]), 64'(mk(1, 1, 8'h22)));
    check("arb_vld2", 64'(valid_o[0]), 64'(1));
    tick();
    drive(1, mk(1, 1, 8'h33), 1'b1);
    drive(3, mk(1, 1, 8'h44), 1'b1);
    tick(); valid_i = '0; tick();
    check("ptr_first", 64'(pckt_o[0 +: PW]), 64'(mk(1, 1, 8'h44)));
    tick();
    check("ptr_second", 64'(pckt_o[0 +: PW]), 64'(mk(1, 1, 8'h33)));
    tick();

    // backpressure on RIGHT
    ready_i[3]  = 1'b0;
    accepted    = 0;
    first_block = -1;
    seq         = 0;
    for (int i = 0; i < 12; i++) begin
      if (!ready_o[0] && first_block < 0) first_block = i;
      if (ready_o[0]) begin
        accepted++;
      end
      drive(0, mk(2, 1, 8'(seq)), 1'b1);
      if (ready_o[0]) seq++;
      tick();
    end
    valid_i = '0;
    check("bp_accepted", 64'(accepted), 64'(9));
    check("bp_block_cycle", 64'(first_block), 64'(9));
    check("bp_hold", 64'(pckt_o[3*PW +: PW]), 64'(mk(2, 1, 8'h00)));
    ready_i[3] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("bp_drain_vld", 64'(valid_o[3]), 64'(1));
      tick();
    end
    check("bp_drained", 64'(valid_o[3]), 64'(0));

    // reset mid-operation discards buffered traffic
    ready_i[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, mk(2, 1, 8'hE0 + 8'(i)), 1'b0);
      tick();
    end
    valid_i = '0;
    rst_ni  = 1'b0;
    tick(); tick();
    check("mrst_ready", 64'(ready_o), 64'(0));
    check("mrst_valid", 64'(valid_o), 64'(0));
    check("mrst_pckt", 64'(pckt_o), 64'(0));
    rst_ni  = 1'b1;
    ready_i = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst_idle", 64'(valid_o), 64'(0));
    end

    // random traffic with random downstream backpressure
    for (int c = 0; c < 400; c++) begin
      valid_i = '0;
      ready_i = PN'($urandom);
      for (int p = 0; p < PN; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          x = $urandom_range(0, 2);
          y = $urandom_range(0, 2);
`ifdef XY_ROUTER_ERR_EN
          while (exp_route(x, y) == p) begin
            x = $urandom_range(0, 2);
            y = $urandom_range(0, 2);
          end
`endif
          drive(p, mk(x, y, {3'(p), 5'(c)}), 1'b1);
        end
      end
      tick();
    end
    valid_i = '0;
    ready_i = '1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
